vliw_fetch_unit: RTL and testbench
==================================

VLIW_FETCH_UNIT -- requirements
Module: vliw_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0: first fetch address after start.
REQ-002 Parameter MEM_BYTES, default 144: instruction memory size in bytes; fetch beyond it halts.
REQ-003 Parameter DEPTH, default 4: bundle FIFO entries, power of two, at least 2.
REQ-004 clk  in  1  clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 start  in  1  one-cycle pulse; leaves IDLE and begins fetching.
REQ-007 mem_pc  out  32  byte address driven to the main memory instruction port (pc_in).
REQ-008 mem_bundle  in  128  combinational bundle returned for mem_pc; slot0 in [127:96].
REQ-009 redirect_valid  in  1  branch/jump redirect request.
REQ-010 redirect_pc  in  32  redirect target byte address.
REQ-011 out_valid  out  1  FIFO head holds a valid bundle.
REQ-012 out_bundle  out  128  FIFO head bundle.
REQ-013 out_pc  out  32  byte address of the head bundle.
REQ-014 out_ready  in  1  downstream (decode) accepts the head this cycle.
REQ-015 halted  out  1  high while in HALT.
REQ-016 occupancy  out  $clog2(DEPTH)+1  FIFO entry count.

Function
REQ-017 States are IDLE, RUN and HALT; the reset state is IDLE.
REQ-018 IDLE goes to RUN on start; HALT goes to RUN only on redirect_valid; in HALT, start is ignored.
REQ-019 mem_pc always equals the internal pc register; mem_bundle is sampled in the same cycle (zero-latency memory).
REQ-020 Push condition: state==RUN, no redirect, pc+16<=MEM_BYTES, mem_bundle!=0, and (occupancy<DEPTH or pop this cycle).
REQ-021 On push, {pc, mem_bundle} is written at the FIFO tail and pc <= pc+16.
REQ-022 In RUN with no redirect, an all-zero mem_bundle or pc+16>MEM_BYTES causes no push, pc holds, and the next state is HALT.
REQ-023 Pop occurs when out_valid && out_ready; the head advances one entry.
REQ-024 out_valid = (occupancy!=0); out_bundle/out_pc are the head entry directly, with no extra register stage.
REQ-025 Simultaneous push and pop on a full FIFO is permitted; occupancy is unchanged.
REQ-026 Redirect has priority over push, pop, halt detection and start: it flushes the FIFO (occupancy<=0), sets pc <= {redirect_pc[31:2],2'b00}, and sets state <= RUN.
REQ-027 A pop coinciding with a redirect still counts as accepted by the consumer, but the flush discards all other entries.
REQ-028 The first redirect-target bundle appears at out_valid two cycles after redirect_valid: a push in the cycle after the redirect, then visible the cycle after that.
REQ-029 Read and write FIFO pointers wrap modulo DEPTH; the pc adder wraps modulo 2^32.
REQ-030 In IDLE and HALT, pc holds and no push occurs; pops continue until the FIFO is empty.

Reset
REQ-031 While rst is high: state=IDLE, pc=RESET_PC, FIFO pointers and occupancy=0, out_valid=0, halted=0; out_bundle and out_pc read as 0.
REQ-032 Reset asserted mid-operation discards all FIFO contents immediately (asynchronously); no pop or push completes in that cycle.

Structure
REQ-033 The shared package vliw_pkg holds BUNDLE_W=128, SLOT_W=32, BUNDLE_BYTES=16, the fetch_state_t enum (IDLE/RUN/HALT), and the fetch_entry_t struct {pc, bundle}.
REQ-034 One sub-module, fetch_fifo (parameterised sync FIFO of fetch_entry_t, with flush input), implements the buffer; the top holds the FSM and pc.

Verification
REQ-035 Memory image with bundles at 0x00..0x20 followed by a zero word at 0x30, out_ready=1, start pulse: out_pc sequence 0x00, 0x10, 0x20; then halted=1 and out_valid=0.
REQ-036 out_ready=0 for 10 cycles after start: occupancy saturates at 4, mem_pc holds at 0x40; releasing out_ready drains in order 0x00..0x30 without loss.
REQ-037 Redirect to 0x20 while FIFO holds 3 entries: occupancy=0 next cycle; first out_pc=0x20 exactly two cycles after the redirect.
REQ-038 redirect_pc=0x13 in HALT: state RUN, mem_pc=0x10.
REQ-039 Full FIFO with out_ready=1 in steady state: one push and one pop per cycle, occupancy stays 4, consecutive out_pc values differ by 0x10.
REQ-040 rst asserted for 1 cycle mid-stream with 3 entries queued: out_valid=0 immediately, mem_pc=RESET_PC, state IDLE; no fetch until the next start.

Source files
------------

// File: rtl/vliw_pkg.sv
// Shared types and constants for the VLIW fetch path.
package vliw_pkg;

  localparam int BUNDLE_W     = 128;
  localparam int SLOT_W       = 32;
  localparam int BUNDLE_BYTES = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT
  } fetch_state_t;

  typedef struct packed {
    logic [31:0]         pc;
    logic [BUNDLE_W-1:0] bundle;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous bundle FIFO with flush; head entry is presented combinationally.
module fetch_fifo
  import vliw_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  fetch_entry_t             push_entry,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  fetch_entry_t     mem [DEPTH];
  logic             do_pop;
  logic             do_push;

  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != FULL_COUNT) || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_entry;
  end

  assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/vliw_fetch_unit.sv
// Bundle fetch unit: IDLE/RUN/HALT sequencer and pc feeding a bundle FIFO.
module vliw_fetch_unit
  import vliw_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter int          MEM_BYTES = 144,
  parameter int          DEPTH     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic [31:0]              mem_pc,
  input  logic [BUNDLE_W-1:0]      mem_bundle,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  output logic                     out_valid,
  output logic [BUNDLE_W-1:0]      out_bundle,
  output logic [31:0]              out_pc,
  input  logic                     out_ready,
  output logic                     halted,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam logic [$clog2(DEPTH):0] FULL_COUNT = ($clog2(DEPTH) + 1)'(DEPTH);

  fetch_state_t state;
  fetch_state_t state_next;
  logic [31:0]  pc;
  logic [31:0]  pc_next;
  logic [31:0]  pc_plus;
  logic         in_range;
  logic         push;
  logic         pop;
  fetch_entry_t push_entry;
  fetch_entry_t head;

  assign pc_plus  = pc + 32'(BUNDLE_BYTES);
  // Bound check is done one bit wider so a pc near 2^32 cannot wrap into range.
  assign in_range = ({1'b0, pc} + 33'(BUNDLE_BYTES)) <= 33'(MEM_BYTES);
  assign pop      = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pc    <= RESET_PC;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    push       = 1'b0;
    if (redirect_valid) begin
      state_next = RUN;
      pc_next    = {redirect_pc[31:2], 2'b00};
    end else begin
      case (state)
        IDLE: if (start) state_next = RUN;
        RUN: begin
          if (!in_range || (mem_bundle == '0)) begin
            state_next = HALT;
          end else if ((occupancy != FULL_COUNT) || pop) begin
            push    = 1'b1;
            pc_next = pc_plus;
          end
        end
        HALT:    state_next = HALT;
        default: state_next = IDLE;
      endcase
    end
  end

  assign push_entry.pc     = pc;
  assign push_entry.bundle = mem_bundle;

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push),
    .pop       (pop),
    .push_entry(push_entry),
    .head      (head),
    .count     (occupancy)
  );

  assign mem_pc     = pc;
  assign out_valid  = (occupancy != '0);
  assign out_pc     = head.pc;
  assign out_bundle = head.bundle;
  assign halted     = (state == HALT);

endmodule

// File: tb/tb_vliw_fetch_unit.sv
// Scoreboard bench for vliw_fetch_unit against a small zero-latency memory image.
module tb_vliw_fetch_unit;

  logic         clk;
  logic         rst;
  logic         start;
  logic [31:0]  mem_pc;
  logic [127:0] mem_bundle;
  logic         redirect_valid;
  logic [31:0]  redirect_pc;
  logic         out_valid;
  logic [127:0] out_bundle;
  logic [31:0]  out_pc;
  logic         out_ready;
  logic         halted;
  logic [2:0]   occupancy;

  typedef struct {
    logic [31:0]  pc;
    logic [127:0] bundle;
  } exp_t;

  exp_t         sb[$];
  logic [127:0] img[9];
  int           total = 0;
  int           bad = 0;

  vliw_fetch_unit #(
    .RESET_PC (32'h0),
    .MEM_BYTES(144),
    .DEPTH    (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .mem_pc        (mem_pc),
    .mem_bundle    (mem_bundle),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_bundle    (out_bundle),
    .out_pc        (out_pc),
    .out_ready     (out_ready),
    .halted        (halted),
    .occupancy     (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    mem_bundle = '0;
    if (mem_pc[31:4] < 28'd9) mem_bundle = img[mem_pc[7:4]];
  end

  function automatic logic [127:0] bundle_of(input logic [31:0] pc);
    return {pc ^ 32'hA5A5_0000, pc + 32'd1, ~pc, 32'h1234_0000 | pc};
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] actual,
                             input logic [127:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic rv, input logic [31:0] rpc);
    start          = s;
    redirect_valid = rv;
    redirect_pc    = rpc;
    step();
    start          = 1'b0;
    redirect_valid = 1'b0;
  endtask

  task automatic load_image(input int zero_idx);
    for (int i = 0; i < 9; i++)
      img[i] = (i == zero_idx) ? 128'h0 : bundle_of(32'(i * 16));
  endtask

  task automatic expect_range(input logic [31:0] first, input logic [31:0] last);
    for (logic [31:0] p = first; p <= last; p += 32'h10) begin
      exp_t e;
      e.pc     = p;
      e.bundle = bundle_of(p);
      sb.push_back(e);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cycles);
    logic ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      if (halted && !out_valid && sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    checkOutput(tag, 128'(ok), 128'd1);
  endtask

  task automatic wait_occ(input string tag, input logic [2:0] n, input int max_cycles);
    logic ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      if (occupancy == n) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    checkOutput(tag, 128'(ok), 128'd1);
  endtask

  // Every accepted head must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checkOutput("sb_unexpected_pop", 128'(sb.size()), 128'd1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("sb_pc", 128'(out_pc), 128'(e.pc));
        checkOutput("sb_bundle", out_bundle, e.bundle);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst            = 1'b1;
    start          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b0;
    load_image(3);
    #3;
    checkOutput("rst_out_valid", 128'(out_valid), 128'd0);
    checkOutput("rst_halted", 128'(halted), 128'd0);
    checkOutput("rst_occupancy", 128'(occupancy), 128'd0);
    checkOutput("rst_mem_pc", 128'(mem_pc), 128'h0);
    checkOutput("rst_out_pc", 128'(out_pc), 128'h0);
    checkOutput("rst_out_bundle", out_bundle, 128'h0);
    #20;
    step();
    rst = 1'b0;
    step();
    checkOutput("idle_no_fetch", 128'(occupancy), 128'd0);

    $display("[TB] short program, zero bundle at 0x30");
    out_ready = 1'b1;
    expect_range(32'h00, 32'h20);
    applyStimulus(1'b1, 1'b0, 32'h0);
    wait_done("t1_drain", 40);
    checkOutput("t1_halted", 128'(halted), 128'd1);
    checkOutput("t1_out_valid", 128'(out_valid), 128'd0);
    checkOutput("t1_mem_pc", 128'(mem_pc), 128'h30);

    $display("[TB] start ignored in HALT, then redirect to 0x13");
    applyStimulus(1'b1, 1'b0, 32'h0);
    step();
    checkOutput("halt_start_ignored", 128'(halted), 128'd1);
    checkOutput("halt_pc_holds", 128'(mem_pc), 128'h30);
    expect_range(32'h10, 32'h20);
    applyStimulus(1'b0, 1'b1, 32'h13);
    checkOutput("redir_halted", 128'(halted), 128'd0);
    checkOutput("redir_mem_pc", 128'(mem_pc), 128'h10);
    wait_done("t4_drain", 40);

    $display("[TB] backpressure then steady-state streaming");
    do_reset();
    load_image(-1);
    out_ready = 1'b0;
    applyStimulus(1'b1, 1'b0, 32'h0);
    repeat (10) step();
    checkOutput("bp_occupancy", 128'(occupancy), 128'd4);
    checkOutput("bp_mem_pc", 128'(mem_pc), 128'h40);
    checkOutput("bp_head_pc", 128'(out_pc), 128'h0);
    expect_range(32'h00, 32'h80);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("steady_occupancy", 128'(occupancy), 128'd4);
    end
    checkOutput("steady_mem_pc", 128'(mem_pc), 128'h70);
    wait_done("t2_drain", 40);
    checkOutput("end_of_mem_pc", 128'(mem_pc), 128'h90);

    $display("[TB] redirect with three queued entries");
    do_reset();
    out_ready = 1'b0;
    applyStimulus(1'b1, 1'b0, 32'h0);
    wait_occ("t3_fill", 3'd3, 20);
    expect_range(32'h20, 32'h80);
    applyStimulus(1'b0, 1'b1, 32'h20);
    checkOutput("flush_occupancy", 128'(occupancy), 128'd0);
    checkOutput("flush_out_valid", 128'(out_valid), 128'd0);
    step();
    checkOutput("redir_first_valid", 128'(out_valid), 128'd1);
    checkOutput("redir_first_pc", 128'(out_pc), 128'h20);
    out_ready = 1'b1;
    wait_done("t3_drain", 40);

    $display("[TB] asynchronous reset mid-stream");
    do_reset();
    out_ready = 1'b0;
    applyStimulus(1'b1, 1'b0, 32'h0);
    wait_occ("t5_fill", 3'd3, 20);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_out_valid", 128'(out_valid), 128'd0);
    checkOutput("arst_occupancy", 128'(occupancy), 128'd0);
    checkOutput("arst_mem_pc", 128'(mem_pc), 128'h0);
    checkOutput("arst_out_pc", 128'(out_pc), 128'h0);
    checkOutput("arst_out_bundle", out_bundle, 128'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) step();
    checkOutput("post_rst_mem_pc", 128'(mem_pc), 128'h0);
    checkOutput("post_rst_occupancy", 128'(occupancy), 128'd0);
    checkOutput("post_rst_halted", 128'(halted), 128'd0);
    out_ready = 1'b1;
    expect_range(32'h00, 32'h80);
    applyStimulus(1'b1, 1'b0, 32'h0);
    wait_done("t5_drain", 60);
    checkOutput("sb_leftover", 128'(sb.size()), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
